uc_multicycle: RTL
==================

// Module: uc_multicycle
// PURPOSE
//  Multicycle control unit for the 6-bit-opcode CPU. Sequences each instruction through
//  FETCH/DECODE/EXEC or memory phases and drives PC, register-file, flag, data-memory and
//  return-stack controls. Sits between instruction memory, data memory and the datapath
//  (PC mux, register file, ALU, zero flag, external return-address stack).
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles waiting for mem_ack before entering ERROR (range 1..255)
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  reset        in   1  synchronous, active-high; state->FETCH, all outputs 0
//  instr_valid  in   1  instruction memory presents valid opcode this cycle
//  opcode       in   6  instruction opcode, sampled only when ir_we=1
//  z            in   1  registered zero flag from datapath
//  mem_ack      in   1  data memory completed request (1-cycle pulse)
//  stack_full   in   1  return stack has no free entry
//  stack_empty  in   1  return stack holds no entry
//  ir_we        out  1  latch instruction (IR and internal opcode register)
//  pc_we        out  1  PC update strobe, exactly one per retired instruction
//  s_inc        out  1  PC source: 1=PC+1, 0=jump target (ignored when s_ret=1)
//  s_ret        out  1  PC source = return-stack top
//  s_inm        out  1  regfile write data: 1=immediate, 0=ALU (ignored when s_mem=1)
//  s_mem        out  1  regfile write data = memory read data
//  we3          out  1  register-file write enable
//  wez          out  1  zero-flag write enable
//  op_alu       out  3  ALU operation = latched opcode[4:2]
//  mem_req      out  1  data memory request, held until mem_ack
//  mem_we       out  1  store qualifier, valid while mem_req=1
//  push, pop    out  1  return-stack push (JAL) / pop (RET)
//  halted       out  1  ERROR state reached; sticky until reset
// BEHAVIOUR
//  Opcode classes (on latched opcode): 0????? ARITH; 1000?? LDI; 100100 BEZ; 100101 BNZ;
//   100110 J; 100111 JAL; 101000 RET; 101001 LIN (load); 101010 STI, 101011 STR (store);
//   all others NOP.
//  States: FETCH, DECODE, EXEC, MEM_REQ, MEM_WB, ERROR. Outputs Moore from state+latched op.
//  FETCH: ir_we=instr_valid; on instr_valid -> DECODE, else stay.
//  DECODE: ARITH/LDI -> EXEC; LIN/STI/STR -> MEM_REQ; branches/J/JAL/RET/NOP retire here:
//   pc_we=1; s_inc=0 if taken (J, JAL, BEZ&z, BNZ&!z) else 1; -> FETCH.
//   JAL: push=1; if stack_full: no pc_we/push, -> ERROR. RET: pop=1, s_ret=1; if
//   stack_empty: no pc_we/pop, -> ERROR. z sampled in DECODE only.
//  EXEC: we3=1, pc_we=1, s_inc=1; ARITH: wez=1, s_inm=0; LDI: wez=0, s_inm=1; -> FETCH.
//  MEM_REQ: mem_req=1, mem_we=1 for STI/STR; timeout counter increments each cycle.
//   mem_ack -> MEM_WB (counter cleared). Counter reaching MEM_TIMEOUT without ack -> ERROR.
//   mem_ack in the same cycle as the limit: ack wins.
//  MEM_WB: pc_we=1, s_inc=1; LIN adds we3=1, s_mem=1; -> FETCH.
//  ERROR: all outputs 0 except halted=1; leaves only on reset.
//  Latency (instr_valid immediate): branch 2, ARITH/LDI 3, memory 4+wait cycles.
//  Exactly one pc_we per retired instruction; we3/wez/push/pop are single-cycle pulses.
//  Reset mid-operation: next edge -> FETCH, mem_req drops, counter cleared, pending op lost.
//  Timeout counter width = $clog2(MEM_TIMEOUT+1); never wraps (saturates at limit).
// STRUCTURE
//  Package uc_pkg: opcode class constants, state encoding localparams, MEM_TIMEOUT default.
//  Sub-module uc_decode: combinational opcode[5:0] -> class one-hot + op_alu; FSM,
//  opcode register and timeout counter live in uc_multicycle.
// TESTING
//  1 reset, opcode=000100, instr_valid=1 -> FETCH,DECODE,EXEC; EXEC: we3=wez=pc_we=1, op_alu=001.
//  2 BEZ 100100 with z=1 -> DECODE pc_we=1,s_inc=0; z=0 -> s_inc=1; BNZ 100101 inverse.
//  3 LIN 101001, mem_ack after 3 cycles -> mem_req held 3 cycles, then MEM_WB we3=s_mem=1.
//  4 STR 101011, no mem_ack, MEM_TIMEOUT=15 -> ERROR after 15 MEM_REQ cycles, halted=1,
//    no we3/pc_we ever.
//  5 JAL with stack_full=1 -> no push, halted=1; RET with stack_empty=0 -> pop=s_ret=pc_we=1.
//  6 reset asserted during MEM_REQ -> next cycle FETCH, all outputs 0, then normal fetch.

Source files
------------

// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - shared types and constants for the multicycle control unit
package uc_pkg;

  localparam int MEM_TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXEC    = 3'd2,
    ST_MEM_REQ = 3'd3,
    ST_MEM_WB  = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  typedef struct packed {
    logic arith;
    logic ldi;
    logic bez;
    logic bnz;
    logic jmp;
    logic jal;
    logic ret;
    logic lin;
    logic sti;
    logic str;
    logic nop;
  } op_class_t;

  localparam logic [3:0] OP_LDI_HI = 4'b1000;
  localparam logic [5:0] OP_BEZ    = 6'b100100;
  localparam logic [5:0] OP_BNZ    = 6'b100101;
  localparam logic [5:0] OP_J      = 6'b100110;
  localparam logic [5:0] OP_JAL    = 6'b100111;
  localparam logic [5:0] OP_RET    = 6'b101000;
  localparam logic [5:0] OP_LIN    = 6'b101001;
  localparam logic [5:0] OP_STI    = 6'b101010;
  localparam logic [5:0] OP_STR    = 6'b101011;

endpackage

// File: rtl/uc_decode.sv
// rtl/uc_decode.sv - opcode to one-hot instruction class and ALU operation
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  cls,
  output logic [2:0] op_alu
);

  always_comb begin
    cls    = '0;
    op_alu = opcode[4:2];
    if (!opcode[5]) begin
      cls.arith = 1'b1;
    end else if (opcode[5:2] == OP_LDI_HI) begin
      cls.ldi = 1'b1;
    end else begin
      unique case (opcode)
        OP_BEZ:  cls.bez = 1'b1;
        OP_BNZ:  cls.bnz = 1'b1;
        OP_J:    cls.jmp = 1'b1;
        OP_JAL:  cls.jal = 1'b1;
        OP_RET:  cls.ret = 1'b1;
        OP_LIN:  cls.lin = 1'b1;
        OP_STI:  cls.sti = 1'b1;
        OP_STR:  cls.str = 1'b1;
        default: cls.nop = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uc_multicycle.sv
// rtl/uc_multicycle.sv - multicycle control FSM with opcode register and memory timeout
module uc_multicycle
  import uc_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [5:0] opcode,
  input  logic       z,
  input  logic       mem_ack,
  input  logic       stack_full,
  input  logic       stack_empty,
  output logic       ir_we,
  output logic       pc_we,
  output logic       s_inc,
  output logic       s_ret,
  output logic       s_inm,
  output logic       s_mem,
  output logic       we3,
  output logic       wez,
  output logic [2:0] op_alu,
  output logic       mem_req,
  output logic       mem_we,
  output logic       push,
  output logic       pop,
  output logic       halted
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT);

  state_t          state_q, state_d;
  logic [5:0]      opcode_q, opcode_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  op_class_t       cls;
  logic [2:0]      alu_op;
  logic            retire_cls;
  logic            taken;

  uc_decode u_decode (
    .opcode (opcode_q),
    .cls    (cls),
    .op_alu (alu_op)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      opcode_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    cnt_d    = '0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    s_inc    = 1'b0;
    s_ret    = 1'b0;
    s_inm    = 1'b0;
    s_mem    = 1'b0;
    we3      = 1'b0;
    wez      = 1'b0;
    op_alu   = alu_op;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    halted   = 1'b0;
    retire_cls = cls.bez | cls.bnz | cls.jmp | cls.jal | cls.ret | cls.nop;
    taken      = cls.jmp | cls.jal | (cls.bez & z) | (cls.bnz & ~z);

    unique case (state_q)
      ST_FETCH: begin
        ir_we = instr_valid;
        if (instr_valid) begin
          opcode_d = opcode;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls.arith | cls.ldi) begin
          state_d = ST_EXEC;
        end else if (cls.lin | cls.sti | cls.str) begin
          state_d = ST_MEM_REQ;
        end else if ((cls.jal & stack_full) | (cls.ret & stack_empty)) begin
          state_d = ST_ERROR;
        end else if (retire_cls) begin
          pc_we   = 1'b1;
          s_inc   = ~taken;
          push    = cls.jal;
          pop     = cls.ret;
          s_ret   = cls.ret;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        we3     = 1'b1;
        pc_we   = 1'b1;
        s_inc   = 1'b1;
        wez     = cls.arith;
        s_inm   = cls.ldi;
        state_d = ST_FETCH;
      end
      ST_MEM_REQ: begin
        mem_req = 1'b1;
        mem_we  = cls.sti | cls.str;
        // An ack on the limit cycle still completes the access.
        if (mem_ack) begin
          state_d = ST_MEM_WB;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
          if (cnt_d == CNT_MAX) state_d = ST_ERROR;
        end
      end
      ST_MEM_WB: begin
        pc_we   = 1'b1;
        s_inc   = 1'b1;
        we3     = cls.lin;
        s_mem   = cls.lin;
        state_d = ST_FETCH;
      end
      ST_ERROR: begin
        op_alu = 3'b000;
        halted = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

endmodule
